// File: rtl/voice_allocator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator_pkg
//  Brief    : Shared types and constants for the voice allocator slice.
//  Revision : 1.0 - initial release
// ============================================================================
package voice_allocator_pkg;

    // Default pitch width, matching the channel_mixer pitch bus.
    localparam int C_PITCH = 12;

    // Waveform select carried with each note-on.
    typedef logic [1:0] wave_t;

    // Allocator sequencing: accept, walk the channels, then apply.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } va_state_t;

    // One note event as seen on the event interface.
    typedef struct packed {
        logic                on;
        logic [C_PITCH-1:0]  pitch;
        wave_t               wave;
    } note_ev_t;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator_if
//  Brief    : Note-event valid/ready handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface voice_allocator_if
    import voice_allocator_pkg::*;
#(
    parameter int C = C_PITCH
) ();

    logic          ev_valid;
    logic          ev_ready;
    logic          ev_on;
    logic [C-1:0]  ev_pitch;
    wave_t         ev_wave;

    // Event producer side.
    modport master (
        output ev_valid,
        output ev_on,
        output ev_pitch,
        output ev_wave,
        input  ev_ready
    );

    // Event consumer side (the allocator).
    modport slave (
        input  ev_valid,
        input  ev_on,
        input  ev_pitch,
        input  ev_wave,
        output ev_ready
    );

endinterface
`default_nettype wire

// File: rtl/voice_allocator_rank.sv
`default_nettype none
// ============================================================================
//  Module   : voice_rank
//  Brief    : Age ranking of channels. Rank 0 is the newest voice and rank
//             NUM-1 the oldest; the ranks always form a permutation.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_rank #(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          upd,
    input  wire logic [IW-1:0] tgt,
    output logic      [IW-1:0] oldest
);

    logic [IW-1:0] rank_q [NUM];
    logic [IW-1:0] rank_d [NUM];
    logic [IW-1:0] tgt_rank;

    // Promote the target to newest; everything younger than it ages by one.
    always_comb begin
        rank_d   = rank_q;
        tgt_rank = rank_q[tgt];
        if (upd) begin
            for (int i = 0; i < NUM; i++) begin
                if (IW'(i) == tgt) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < tgt_rank) begin
                    rank_d[i] = rank_q[i] + IW'(1);
                end
            end
        end
    end

    // Locate the channel holding the oldest rank.
    always_comb begin
        oldest = '0;
        for (int i = 0; i < NUM; i++) begin
            if (rank_q[i] == IW'(NUM - 1)) begin
                oldest = IW'(i);
            end
        end
    end

    // Rank register; reset gives channel i rank i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                rank_q[i] <= IW'(i);
            end
        end else begin
            rank_q <= rank_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : voice_allocator
//  Brief    : Note-event controller for channel_mixer. Retriggers a matching
//             channel, else fills the lowest free one, else steals the oldest.
//  Revision : 1.0 - initial release
// ============================================================================
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM = 4,
    parameter int C   = C_PITCH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    voice_allocator_if.slave              ev,
    input  wire logic                     panic,
    output logic [NUM*C-1:0]              pitches,
    output logic [NUM-1:0]                channel_ena,
    output logic [NUM*2-1:0]              waveforms,
    output logic [$clog2(NUM+1)-1:0]      active_count,
    output logic                          steal
);

    localparam int IW = $clog2(NUM);
    localparam int CW = $clog2(NUM + 1);

    va_state_t      state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic           on_q, on_d;
    logic [C-1:0]   evp_q, evp_d;
    wave_t          evw_q, evw_d;

    logic           match_found_q, match_found_d;
    logic [IW-1:0]  match_idx_q, match_idx_d;
    logic           free_found_q, free_found_d;
    logic [IW-1:0]  free_idx_q, free_idx_d;

    logic [C-1:0]   pitch_q [NUM];
    logic [C-1:0]   pitch_d [NUM];
    wave_t          wave_q  [NUM];
    wave_t          wave_d  [NUM];
    logic [NUM-1:0] ena_q, ena_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           steal_q, steal_d;

    logic           rank_upd;
    logic [IW-1:0]  rank_tgt;
    logic [IW-1:0]  oldest;
    logic           accept;

    // Ready is gated by panic and reset directly so no event slips in then.
    assign ev.ev_ready = (state_q == IDLE) && !panic && !rst;
    assign accept      = ev.ev_valid && ev.ev_ready;

    voice_rank #(
        .NUM (NUM),
        .IW  (IW)
    ) u_rank (
        .clk    (clk),
        .rst    (rst),
        .upd    (rank_upd),
        .tgt    (rank_tgt),
        .oldest (oldest)
    );

    // Sequencing, channel scan and commit of the latched event.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        on_d          = on_q;
        evp_d         = evp_q;
        evw_d         = evw_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        pitch_d       = pitch_q;
        wave_d        = wave_q;
        ena_d         = ena_q;
        steal_d       = 1'b0;
        rank_upd      = 1'b0;
        rank_tgt      = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    on_d          = ev.ev_on;
                    evp_d         = ev.ev_pitch;
                    evw_d         = ev.ev_wave;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    free_found_d  = 1'b0;
                    free_idx_d    = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                if (!match_found_q && ena_q[idx_q] && (pitch_q[idx_q] == evp_q)) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!free_found_q && !ena_q[idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (idx_q == IW'(NUM - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (on_q) begin
                    rank_upd = 1'b1;
                    if (match_found_q) begin
                        rank_tgt            = match_idx_q;
                        wave_d[match_idx_q] = evw_q;
                    end else if (free_found_q) begin
                        rank_tgt            = free_idx_q;
                        pitch_d[free_idx_q] = evp_q;
                        wave_d[free_idx_q]  = evw_q;
                        ena_d[free_idx_q]   = 1'b1;
                    end else begin
                        rank_tgt        = oldest;
                        pitch_d[oldest] = evp_q;
                        wave_d[oldest]  = evw_q;
                        ena_d[oldest]   = 1'b1;
                        steal_d         = 1'b1;
                    end
                end else if (match_found_q) begin
                    ena_d[match_idx_q] = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Panic wins over everything, including a commit in the same cycle.
        if (panic) begin
            state_d  = IDLE;
            ena_d    = '0;
            steal_d  = 1'b0;
            rank_upd = 1'b0;
        end
    end

    // Active voice count follows the next enable vector so it stays aligned.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM; i++) begin
            cnt_d = cnt_d + {{(CW-1){1'b0}}, ena_d[i]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            on_q          <= 1'b0;
            evp_q         <= '0;
            evw_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            for (int i = 0; i < NUM; i++) begin
                pitch_q[i] <= '0;
                wave_q[i]  <= '0;
            end
            ena_q         <= '0;
            cnt_q         <= '0;
            steal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            on_q          <= on_d;
            evp_q         <= evp_d;
            evw_q         <= evw_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            pitch_q       <= pitch_d;
            wave_q        <= wave_d;
            ena_q         <= ena_d;
            cnt_q         <= cnt_d;
            steal_q       <= steal_d;
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_out
        assign pitches[C*gi +: C]   = pitch_q[gi];
        assign waveforms[2*gi +: 2] = wave_q[gi];
    end

    assign channel_ena  = ena_q;
    assign active_count = cnt_q;
    assign steal        = steal_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_voice_allocator
//  Brief    : Directed, table-driven bench for voice_allocator (NUM=4, C=12).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int NUM = 4;
    localparam int C   = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              panic = 1'b0;
    logic [NUM*C-1:0]  pitches;
    logic [NUM-1:0]    channel_ena;
    logic [NUM*2-1:0]  waveforms;
    logic [2:0]        active_count;
    logic              steal;

    always #5 clk = ~clk;

    voice_allocator_if #(.C(C)) intf ();

    voice_allocator #(.NUM(NUM), .C(C)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev           (intf.slave),
        .panic        (panic),
        .pitches      (pitches),
        .channel_ena  (channel_ena),
        .waveforms    (waveforms),
        .active_count (active_count),
        .steal        (steal)
    );

    typedef struct {
        note_ev_t    ev;
        logic [3:0]  ena;
        logic [47:0] pit;
        logic [7:0]  wav;
        logic [2:0]  cnt;
        logic        stl;
        logic [7:0]  rnk;   // {rank3, rank2, rank1, rank0}
    } vec_t;

    vec_t vecs [9];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic on, input logic [11:0] p, input logic [1:0] w,
                                input logic [3:0] ena, input logic [47:0] pit,
                                input logic [7:0] wav, input logic [2:0] cnt,
                                input logic stl, input logic [7:0] rnk);
        vec_t v;
        v.ev.on    = on;
        v.ev.pitch = p;
        v.ev.wave  = w;
        v.ena = ena; v.pit = pit; v.wav = wav; v.cnt = cnt; v.stl = stl; v.rnk = rnk;
        return v;
    endfunction

    function automatic logic [7:0] ranks();
        return {dut.u_rank.rank_q[3], dut.u_rank.rank_q[2],
                dut.u_rank.rank_q[1], dut.u_rank.rank_q[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one event, then follow it through scan and commit cycle by cycle.
    task automatic send(input note_ev_t e, input logic exp_steal);
        int n;
        intf.ev_valid = 1'b1;
        intf.ev_on    = e.on;
        intf.ev_pitch = e.pitch;
        intf.ev_wave  = e.wave;
        n = 0;
        while (intf.ev_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(intf.ev_ready), 64'd1);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) intf.ev_valid = 1'b0;
            check("busy_no_ready", 64'({intf.ev_ready, steal}), 64'd0);
        end
        @(negedge clk);
        check("gap_ready", 64'(intf.ev_ready), 64'd1);
        check("steal_at_commit", 64'(steal), 64'(exp_steal));
    endtask

    task automatic apply(input vec_t v);
        send(v.ev, v.stl);
        check("ena",     64'(channel_ena),  64'(v.ena));
        check("pitches", 64'(pitches),      64'(v.pit));
        check("waves",   64'(waveforms),    64'(v.wav));
        check("count",   64'(active_count), 64'(v.cnt));
        check("ranks",   64'(ranks()),      64'(v.rnk));
        @(negedge clk);
        check("steal_one_cycle", 64'(steal), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(1'b1, 12'd100, 2'd0, 4'b0001, {12'd0,   12'd0,   12'd0,   12'd100}, 8'h00, 3'd1, 1'b0, 8'hE4);
        vecs[1] = mk(1'b1, 12'd200, 2'd0, 4'b0011, {12'd0,   12'd0,   12'd200, 12'd100}, 8'h00, 3'd2, 1'b0, 8'hE1);
        vecs[2] = mk(1'b1, 12'd300, 2'd0, 4'b0111, {12'd0,   12'd300, 12'd200, 12'd100}, 8'h00, 3'd3, 1'b0, 8'hC6);
        vecs[3] = mk(1'b1, 12'd400, 2'd0, 4'b1111, {12'd400, 12'd300, 12'd200, 12'd100}, 8'h00, 3'd4, 1'b0, 8'h1B);
        vecs[4] = mk(1'b1, 12'd500, 2'd0, 4'b1111, {12'd400, 12'd300, 12'd200, 12'd500}, 8'h00, 3'd4, 1'b1, 8'h6C);
        vecs[5] = mk(1'b0, 12'd300, 2'd0, 4'b1011, {12'd400, 12'd300, 12'd200, 12'd500}, 8'h00, 3'd3, 1'b0, 8'h6C);
        vecs[6] = mk(1'b0, 12'd999, 2'd0, 4'b1011, {12'd400, 12'd300, 12'd200, 12'd500}, 8'h00, 3'd3, 1'b0, 8'h6C);
        vecs[7] = mk(1'b1, 12'd600, 2'd0, 4'b1111, {12'd400, 12'd600, 12'd200, 12'd500}, 8'h00, 3'd4, 1'b0, 8'h8D);
        vecs[8] = mk(1'b1, 12'd200, 2'd3, 4'b1111, {12'd400, 12'd600, 12'd200, 12'd500}, 8'h0C, 3'd4, 1'b0, 8'hD2);

        intf.ev_valid = 1'b0;
        intf.ev_on    = 1'b0;
        intf.ev_pitch = '0;
        intf.ev_wave  = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({pitches, channel_ena, waveforms, active_count, steal}), 64'd0);
        check("rst_ready",   64'(intf.ev_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(intf.ev_ready), 64'd1);
        check("post_rst_ranks", 64'(ranks()), 64'hE4);

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
        end

        // Panic during SCAN drops the in-flight note-on.
        intf.ev_valid = 1'b1;
        intf.ev_on    = 1'b1;
        intf.ev_pitch = 12'd700;
        intf.ev_wave  = 2'd2;
        check("panic_pre_ready", 64'(intf.ev_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        intf.ev_valid = 1'b0;
        panic = 1'b1;
        @(negedge clk);
        check("panic_ena",   64'(channel_ena),    64'd0);
        check("panic_count", 64'(active_count),   64'd0);
        check("panic_ready", 64'(intf.ev_ready),  64'd0);
        panic = 1'b0;
        @(negedge clk);
        check("after_panic_ready",   64'(intf.ev_ready), 64'd1);
        check("after_panic_pitches", 64'(pitches),
              64'({12'd400, 12'd600, 12'd200, 12'd500}));
        check("after_panic_waves",   64'(waveforms), 64'h0C);
        check("after_panic_ranks",   64'(ranks()),   64'hD2);
        repeat (6) @(negedge clk);
        check("dropped_event", 64'({channel_ena, steal}), 64'd0);

        // Event offered while panic is high must not be taken.
        panic = 1'b1;
        intf.ev_valid = 1'b1;
        intf.ev_on    = 1'b1;
        intf.ev_pitch = 12'd800;
        intf.ev_wave  = 2'd1;
        #1;
        check("panic_blocks_ready", 64'(intf.ev_ready), 64'd0);
        @(negedge clk);
        panic = 1'b0;
        intf.ev_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("no_handshake_ena", 64'(channel_ena), 64'd0);
        check("no_handshake_pitches", 64'(pitches),
              64'({12'd400, 12'd600, 12'd200, 12'd500}));

        // Fresh note-on after panic lands on the lowest channel, which ages ranks.
        apply(mk(1'b1, 12'd200, 2'd1, 4'b0001, {12'd400, 12'd600, 12'd200, 12'd200},
                 8'h0D, 3'd1, 1'b0, 8'hE4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
